// File: rtl/hazard_pkg.sv
// ============================================================================
// hazard_pkg : shared types and constants for the pipeline hazard controller
// Revision   : 1.0
// ============================================================================
`default_nettype none

package hazard_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        FLUSH  = 2'd1,
        DRAIN  = 2'd2,
        HALTED = 2'd3
    } state_t;

    localparam logic [1:0]  FWD_RF = 2'b00;
    localparam logic [1:0]  FWD_M  = 2'b10;
    localparam logic [1:0]  FWD_W  = 2'b01;

    localparam logic [31:0] DEFAULT_HALT_WORD = 32'hffff_ffff;
    localparam int          CNT_W             = 4;

endpackage

`default_nettype wire

// File: rtl/hazard_ctrl_if.sv
// ============================================================================
// hazard_ctrl_if : pipeline fields in, stall/flush/forward controls out
// Revision       : 1.0
// ============================================================================
`default_nettype none

interface hazard_ctrl_if;
    logic [31:0] instrF;
    logic [4:0]  rsD, rtD, rsE, rtE;
    logic [4:0]  writeRegE, writeRegM, writeRegW;
    logic        memReadE;
    logic        regWriteE, regWriteM, regWriteW;
    logic        redirectE;
    logic        stallF, stallD, flushD, flushE;
    logic [1:0]  fwdAE, fwdBE;
    logic        halted;
    logic [31:0] cycle_cnt;

    modport master (
        output instrF, rsD, rtD, rsE, rtE, writeRegE, writeRegM, writeRegW,
               memReadE, regWriteE, regWriteM, regWriteW, redirectE,
        input  stallF, stallD, flushD, flushE, fwdAE, fwdBE, halted, cycle_cnt
    );

    modport slave (
        input  instrF, rsD, rtD, rsE, rtE, writeRegE, writeRegM, writeRegW,
               memReadE, regWriteE, regWriteM, regWriteW, redirectE,
        output stallF, stallD, flushD, flushE, fwdAE, fwdBE, halted, cycle_cnt
    );
endinterface

`default_nettype wire

// File: rtl/hazard_ctrl_fwd_sel.sv
// ============================================================================
// fwd_sel  : EX operand forward select for one source register (M beats W)
// Revision : 1.0
// ============================================================================
`default_nettype none

module fwd_sel
    import hazard_pkg::*;
(
    input  logic [4:0] src,
    input  logic       reg_write_m,
    input  logic [4:0] write_reg_m,
    input  logic       reg_write_w,
    input  logic [4:0] write_reg_w,
    output logic [1:0] fwd
);

    always_comb begin
        fwd = FWD_RF;
        if (reg_write_m && (write_reg_m != 5'd0) && (write_reg_m == src)) begin
            fwd = FWD_M;
        end else if (reg_write_w && (write_reg_w != 5'd0) && (write_reg_w == src)) begin
            fwd = FWD_W;
        end
    end

endmodule

`default_nettype wire

// File: rtl/hazard_ctrl.sv
// ============================================================================
// hazard_ctrl : redirect squash, RAW stall, halt drain and EX forwarding.
//               Macro HAZARD_FWD_EN enables forwarding; without it every RAW
//               hazard against EX/MEM stalls instead.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int          SQUASH_CYCLES = 2,
    parameter int          DRAIN_CYCLES  = 4,
    parameter logic [31:0] HALT_WORD     = DEFAULT_HALT_WORD
) (
    input  logic         clk,
    input  logic         rst_n,
    hazard_ctrl_if.slave bus
);

    // The triggering cycle counts as the first squash/drain cycle.
    localparam int             SQUASH_LOAD_I = (SQUASH_CYCLES > 1) ? SQUASH_CYCLES - 2 : 0;
    localparam int             DRAIN_LOAD_I  = (DRAIN_CYCLES  > 1) ? DRAIN_CYCLES  - 2 : 0;
    localparam logic [CNT_W-1:0] SQUASH_LOAD = CNT_W'(SQUASH_LOAD_I);
    localparam logic [CNT_W-1:0] DRAIN_LOAD  = CNT_W'(DRAIN_LOAD_I);

    state_t           r_state, w_state_next;
    logic [CNT_W-1:0] r_cnt, w_cnt_next;
    logic [31:0]      r_cycle_cnt;

    logic w_match_e, w_load_use, w_hazard;
    logic w_stall_f, w_stall_d, w_flush_d, w_flush_e;

    assign w_match_e  = (bus.writeRegE != 5'd0) &&
                        ((bus.writeRegE == bus.rsD) || (bus.writeRegE == bus.rtD));
    assign w_load_use = bus.memReadE & w_match_e;

`ifdef HAZARD_FWD_EN
    logic [1:0] w_fwd_a, w_fwd_b;

    fwd_sel u_fwd_a (
        .src         (bus.rsE),
        .reg_write_m (bus.regWriteM),
        .write_reg_m (bus.writeRegM),
        .reg_write_w (bus.regWriteW),
        .write_reg_w (bus.writeRegW),
        .fwd         (w_fwd_a)
    );

    fwd_sel u_fwd_b (
        .src         (bus.rtE),
        .reg_write_m (bus.regWriteM),
        .write_reg_m (bus.writeRegM),
        .reg_write_w (bus.regWriteW),
        .write_reg_w (bus.writeRegW),
        .fwd         (w_fwd_b)
    );

    assign w_hazard  = w_load_use;
    assign bus.fwdAE = rst_n ? w_fwd_a : FWD_RF;
    assign bus.fwdBE = rst_n ? w_fwd_b : FWD_RF;
`else
    logic w_match_m;
    logic w_unused;

    assign w_match_m = (bus.writeRegM != 5'd0) &&
                       ((bus.writeRegM == bus.rsD) || (bus.writeRegM == bus.rtD));
    // Write-first register file covers WB, so only EX and MEM producers stall.
    assign w_hazard  = w_load_use | (bus.regWriteE & w_match_e) | (bus.regWriteM & w_match_m);
    assign bus.fwdAE = FWD_RF;
    assign bus.fwdBE = FWD_RF;
    assign w_unused  = ^{bus.rsE, bus.rtE, bus.regWriteW, bus.writeRegW};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= RUN;
            r_cnt       <= '0;
            r_cycle_cnt <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            if (r_state != HALTED) begin
                r_cycle_cnt <= r_cycle_cnt + 32'd1;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_stall_f    = 1'b0;
        w_stall_d    = 1'b0;
        w_flush_d    = 1'b0;
        w_flush_e    = 1'b0;
        unique case (r_state)
            RUN: begin
                if (bus.redirectE) begin
                    w_flush_d = 1'b1;
                    w_flush_e = 1'b1;
                    if (SQUASH_CYCLES > 1) begin
                        w_state_next = FLUSH;
                        w_cnt_next   = SQUASH_LOAD;
                    end
                end else if (w_hazard) begin
                    w_stall_f = 1'b1;
                    w_stall_d = 1'b1;
                    w_flush_e = 1'b1;
                end else if (bus.instrF == HALT_WORD) begin
                    w_stall_f = 1'b1;
                    w_flush_d = 1'b1;
                    if (DRAIN_CYCLES > 1) begin
                        w_state_next = DRAIN;
                        w_cnt_next   = DRAIN_LOAD;
                    end else begin
                        w_state_next = HALTED;
                    end
                end
            end
            FLUSH: begin
                w_flush_d = 1'b1;
                w_flush_e = 1'b1;
                if (r_cnt == '0) begin
                    w_state_next = RUN;
                end else begin
                    w_cnt_next = r_cnt - 1'b1;
                end
            end
            DRAIN: begin
                // An older redirect invalidates the halt word that is draining.
                if (bus.redirectE) begin
                    w_flush_d = 1'b1;
                    w_flush_e = 1'b1;
                    w_state_next = (SQUASH_CYCLES > 1) ? FLUSH : RUN;
                    w_cnt_next   = SQUASH_LOAD;
                end else begin
                    w_stall_f = 1'b1;
                    w_flush_d = 1'b1;
                    if (r_cnt == '0) begin
                        w_state_next = HALTED;
                    end else begin
                        w_cnt_next = r_cnt - 1'b1;
                    end
                end
            end
            HALTED: begin
                w_stall_f = 1'b1;
                w_stall_d = 1'b1;
                w_flush_d = 1'b1;
                w_flush_e = 1'b1;
            end
            default: begin
                w_state_next = RUN;
                w_cnt_next   = '0;
            end
        endcase
    end

    assign bus.stallF    = rst_n & w_stall_f;
    assign bus.stallD    = rst_n & w_stall_d;
    assign bus.flushD    = rst_n & w_flush_d;
    assign bus.flushE    = rst_n & w_flush_e;
    assign bus.halted    = (r_state == HALTED);
    assign bus.cycle_cnt = r_cycle_cnt;

endmodule

`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
// ============================================================================
// tb_hazard_ctrl : scoreboard bench for hazard_ctrl (either HAZARD_FWD_EN build)
// Revision       : 1.0
// ============================================================================
`default_nettype none

module tb_hazard_ctrl;
    import hazard_pkg::*;

    localparam int SQ = 2;
    localparam int DR = 4;
`ifdef HAZARD_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    // {stallF, stallD, flushD, flushE}
    localparam logic [3:0] NONE = 4'b0000;
    localparam logic [3:0] STL  = 4'b1101;
    localparam logic [3:0] FLS  = 4'b0011;
    localparam logic [3:0] DRN  = 4'b1010;
    localparam logic [3:0] HLT  = 4'b1111;
    localparam logic [31:0] HW  = 32'hffff_ffff;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    hazard_ctrl_if bus();

    hazard_ctrl #(
        .SQUASH_CYCLES (SQ),
        .DRAIN_CYCLES  (DR),
        .HALT_WORD     (HW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] model_cnt    = '0;
    bit          model_frozen = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)             model_cnt <= '0;
        else if (!model_frozen) model_cnt <= model_cnt + 32'd1;
    end

    typedef struct packed {
        logic [8:0]  o;
        logic [31:0] cnt;
    } exp_t;

    typedef struct {
        logic [31:0] instr;
        logic [4:0]  rsD, rtD, rsE, rtE, wE, wM, wW;
        logic        memRd, rwE, rwM, rwW, redir;
        logic [3:0]  ctl;
        logic        halted;
    } vec_t;

    exp_t sb[$];

    function automatic logic [8:0] outs();
        return {bus.stallF, bus.stallD, bus.flushD, bus.flushE, bus.fwdAE, bus.fwdBE, bus.halted};
    endfunction

    function automatic logic [1:0] fwd_exp(logic [4:0] src, logic rwm, logic [4:0] wm,
                                           logic rww, logic [4:0] ww);
        if (!FWD || src == 5'd0) return 2'b00;
        if (rwm && wm == src)    return 2'b10;
        if (rww && ww == src)    return 2'b01;
        return 2'b00;
    endfunction

    function automatic vec_t idle_vec();
        vec_t v;
        v.instr = 32'h0000_0013;
        {v.rsD, v.rtD, v.rsE, v.rtE, v.wE, v.wM, v.wW} = '0;
        {v.memRd, v.rwE, v.rwM, v.rwW, v.redir} = '0;
        v.ctl = NONE;
        v.halted = 1'b0;
        return v;
    endfunction

    task automatic apply(input vec_t v);
        bus.instrF    = v.instr;
        bus.rsD       = v.rsD;
        bus.rtD       = v.rtD;
        bus.rsE       = v.rsE;
        bus.rtE       = v.rtE;
        bus.writeRegE = v.wE;
        bus.writeRegM = v.wM;
        bus.writeRegW = v.wW;
        bus.memReadE  = v.memRd;
        bus.regWriteE = v.rwE;
        bus.regWriteM = v.rwM;
        bus.regWriteW = v.rwW;
        bus.redirectE = v.redir;
    endtask

    function automatic exp_t expect_of(vec_t v);
        exp_t e;
        e.o   = {v.ctl, fwd_exp(v.rsE, v.rwM, v.wM, v.rwW, v.wW),
                 fwd_exp(v.rtE, v.rwM, v.wM, v.rwW, v.wW), v.halted};
        e.cnt = model_cnt;
        return e;
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        apply(idle_vec());
        rst_n        = 1'b0;
        model_frozen = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        vec_t v;
        exp_t e;
        v = idle_vec();
        v.redir = 1'b1; v.memRd = 1'b1; v.wE = 5'd5; v.rsD = 5'd5;
        v.rsE = 5'd7; v.rwM = 1'b1; v.wM = 5'd7; v.instr = HW;
        apply(v);
        for (int i = 0; i < 2; i++) begin
            #1;
            sb.push_back('{o: 9'd0, cnt: 32'd0});
            e = sb.pop_front();
            n_checks++;
            if ({outs(), bus.cycle_cnt} !== {e.o, e.cnt})
                $display("FAIL reset[%0d]: got out=%b cnt=%0d, want out=%b cnt=%0d",
                         i, outs(), bus.cycle_cnt, e.o, e.cnt);
            if ({outs(), bus.cycle_cnt} !== {e.o, e.cnt}) n_fail++;
            @(posedge clk);
        end
        apply(idle_vec());
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_load_use();
        vec_t vs[$];
        vec_t v;
        exp_t e;
        v = idle_vec(); vs.push_back(v);
        v = idle_vec(); v.memRd = 1; v.wE = 5'd5; v.rsD = 5'd5; v.ctl = STL; vs.push_back(v);
        v = idle_vec(); vs.push_back(v);
        v = idle_vec(); v.memRd = 1; v.wE = 5'd0; v.rsD = 5'd0; vs.push_back(v);
        v = idle_vec(); v.memRd = 1; v.wE = 5'd6; v.rtD = 5'd6; v.ctl = STL; vs.push_back(v);
        v = idle_vec(); v.memRd = 1; v.wE = 5'd6; v.rsD = 5'd2; v.rtD = 5'd3; vs.push_back(v);
        v = idle_vec(); v.memRd = 1; v.wE = 5'd5; v.rsD = 5'd5; v.instr = HW; v.ctl = STL; vs.push_back(v);
        v = idle_vec(); vs.push_back(v);
        foreach (vs[i]) begin
            next_cycle();
            apply(vs[i]);
            sb.push_back(expect_of(vs[i]));
            @(negedge clk);
            e = sb.pop_front();
            n_checks++;
            if ({outs(), bus.cycle_cnt} !== {e.o, e.cnt}) begin
                n_fail++;
                $display("FAIL load_use[%0d]: got out=%b cnt=%0d, want out=%b cnt=%0d",
                         i, outs(), bus.cycle_cnt, e.o, e.cnt);
            end
        end
    endtask

    task automatic test_redirect();
        vec_t vs[$];
        vec_t v, lu;
        exp_t e;
        lu = idle_vec(); lu.memRd = 1; lu.wE = 5'd5; lu.rsD = 5'd5;
        v = idle_vec(); v.redir = 1; v.ctl = FLS; vs.push_back(v);
        v = idle_vec(); v.ctl = FLS; vs.push_back(v);
        v = idle_vec(); vs.push_back(v);
        v = lu; v.redir = 1; v.ctl = FLS; vs.push_back(v);
        v = lu; v.ctl = FLS; vs.push_back(v);
        v = lu; v.ctl = STL; vs.push_back(v);
        v = idle_vec(); vs.push_back(v);
        foreach (vs[i]) begin
            next_cycle();
            apply(vs[i]);
            sb.push_back(expect_of(vs[i]));
            @(negedge clk);
            e = sb.pop_front();
            n_checks++;
            if ({outs(), bus.cycle_cnt} !== {e.o, e.cnt}) begin
                n_fail++;
                $display("FAIL redirect[%0d]: got out=%b cnt=%0d, want out=%b cnt=%0d",
                         i, outs(), bus.cycle_cnt, e.o, e.cnt);
            end
        end
    endtask

    task automatic test_forward();
        vec_t vs[$];
        vec_t v;
        exp_t e;
        v = idle_vec(); v.rsE = 5'd7; v.rwM = 1; v.wM = 5'd7; v.rwW = 1; v.wW = 5'd7; vs.push_back(v);
        v.rwM = 0; vs.push_back(v);
        v = idle_vec(); v.rsE = 5'd0; v.rtE = 5'd0; v.rwM = 1; v.rwW = 1; vs.push_back(v);
        v = idle_vec(); v.rsE = 5'd3; v.rtE = 5'd4; v.rwM = 1; v.wM = 5'd4; v.rwW = 1; v.wW = 5'd3; vs.push_back(v);
        v = idle_vec(); v.rtE = 5'd9; v.rwW = 1; v.wW = 5'd9; vs.push_back(v);
        v = idle_vec(); v.rwM = 1; v.wM = 5'd9; v.rsD = 5'd9; v.ctl = FWD ? NONE : STL; vs.push_back(v);
        v = idle_vec(); v.rwE = 1; v.wE = 5'd3; v.rtD = 5'd3; v.ctl = FWD ? NONE : STL; vs.push_back(v);
        v = idle_vec(); v.rwW = 1; v.wW = 5'd4; v.rsD = 5'd4; vs.push_back(v);
        foreach (vs[i]) begin
            next_cycle();
            apply(vs[i]);
            sb.push_back(expect_of(vs[i]));
            @(negedge clk);
            e = sb.pop_front();
            n_checks++;
            if ({outs(), bus.cycle_cnt} !== {e.o, e.cnt}) begin
                n_fail++;
                $display("FAIL forward[%0d]: got out=%b cnt=%0d, want out=%b cnt=%0d",
                         i, outs(), bus.cycle_cnt, e.o, e.cnt);
            end
        end
    endtask

    task automatic test_drain_redirect();
        vec_t vs[$];
        vec_t v;
        exp_t e;
        v = idle_vec(); v.instr = HW; v.ctl = DRN; vs.push_back(v);
        v = idle_vec(); v.instr = HW; v.redir = 1; v.ctl = FLS; vs.push_back(v);
        v = idle_vec(); v.ctl = FLS; vs.push_back(v);
        v = idle_vec(); vs.push_back(v);
        v = idle_vec(); vs.push_back(v);
        foreach (vs[i]) begin
            next_cycle();
            apply(vs[i]);
            sb.push_back(expect_of(vs[i]));
            @(negedge clk);
            e = sb.pop_front();
            n_checks++;
            if ({outs(), bus.cycle_cnt} !== {e.o, e.cnt}) begin
                n_fail++;
                $display("FAIL drain_redirect[%0d]: got out=%b cnt=%0d, want out=%b cnt=%0d",
                         i, outs(), bus.cycle_cnt, e.o, e.cnt);
            end
        end
    endtask

    task automatic test_halt();
        vec_t vs[$];
        vec_t v;
        exp_t e;
        for (int i = 0; i < DR; i++) begin
            v = idle_vec(); v.instr = HW; v.ctl = DRN; vs.push_back(v);
        end
        for (int i = 0; i < 3; i++) begin
            v = idle_vec(); v.instr = HW; v.ctl = HLT; v.halted = 1; v.redir = (i == 2); vs.push_back(v);
        end
        foreach (vs[i]) begin
            next_cycle();
            if (i == DR) model_frozen = 1'b1;
            apply(vs[i]);
            sb.push_back(expect_of(vs[i]));
            @(negedge clk);
            e = sb.pop_front();
            n_checks++;
            if ({outs(), bus.cycle_cnt} !== {e.o, e.cnt}) begin
                n_fail++;
                $display("FAIL halt[%0d]: got out=%b cnt=%0d, want out=%b cnt=%0d",
                         i, outs(), bus.cycle_cnt, e.o, e.cnt);
            end
        end
        apply_reset();
    endtask

    task automatic test_reset_mid_flush();
        vec_t vs[$];
        vec_t v;
        exp_t e;
        v = idle_vec(); v.redir = 1; v.ctl = FLS; vs.push_back(v);
        v = idle_vec(); v.ctl = FLS; vs.push_back(v);
        v = idle_vec(); vs.push_back(v);
        v = idle_vec(); v.instr = HW; v.ctl = DRN; vs.push_back(v);
        v = idle_vec(); v.ctl = DRN; vs.push_back(v);
        foreach (vs[i]) begin
            if (i == 2) begin
                rst_n = 1'b0;
                #1;
                sb.push_back('{o: 9'd0, cnt: 32'd0});
                e = sb.pop_front();
                n_checks++;
                if ({outs(), bus.cycle_cnt} !== {e.o, e.cnt}) begin
                    n_fail++;
                    $display("FAIL reset_mid_flush[async]: got out=%b cnt=%0d, want out=%b cnt=%0d",
                             outs(), bus.cycle_cnt, e.o, e.cnt);
                end
                apply(idle_vec());
                repeat (2) @(posedge clk);
                @(negedge clk);
                rst_n = 1'b1;
            end
            next_cycle();
            apply(vs[i]);
            sb.push_back(expect_of(vs[i]));
            @(negedge clk);
            e = sb.pop_front();
            n_checks++;
            if ({outs(), bus.cycle_cnt} !== {e.o, e.cnt}) begin
                n_fail++;
                $display("FAIL reset_mid_flush[%0d]: got out=%b cnt=%0d, want out=%b cnt=%0d",
                         i, outs(), bus.cycle_cnt, e.o, e.cnt);
            end
        end
        apply_reset();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        apply(idle_vec());
        test_reset();
        test_load_use();
        test_redirect();
        test_forward();
        test_drain_redirect();
        test_halt();
        test_reset_mid_flush();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
